// File: rtl/hamm_secded_decoder_pipe_if.sv
// Read-data ECC bus bundle for hamm_secded_decoder_pipe: codeword input channel and decoded result channel.
interface hamm_secded_decoder_pipe_if #(
  parameter int unsigned DATA_W = 4
);
  // Smallest P with 2**P >= DATA_W+P+1
  function automatic int unsigned calc_p(input int unsigned dw);
    int unsigned p;
    p = 1;
    while ((32'd1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  localparam int unsigned P      = calc_p(DATA_W);
  localparam int unsigned CODE_W = DATA_W + P + 1;
  localparam int unsigned POS_W  = $clog2(CODE_W);

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              in_parity_type;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_single_err;
  logic              out_double_err;
  logic [POS_W-1:0]  out_err_pos;

  modport master (
    output in_valid, in_code, in_parity_type, out_ready,
    input  in_ready, out_valid, out_data, out_single_err, out_double_err, out_err_pos
  );

  modport slave (
    input  in_valid, in_code, in_parity_type, out_ready,
    output in_ready, out_valid, out_data, out_single_err, out_double_err, out_err_pos
  );
endinterface

// File: rtl/hamm_secded_decoder_pipe.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready flow control.
// Optional saturating error counters enabled by defining HAMM_ERR_CNT_EN.
module hamm_secded_decoder_pipe #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  hamm_secded_decoder_pipe_if.slave bus,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          corr_cnt,
  output logic [CNT_W-1:0]          uncorr_cnt
);
  function automatic int unsigned calc_p(input int unsigned dw);
    int unsigned p;
    p = 1;
    while ((32'd1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  localparam int unsigned P      = calc_p(DATA_W);
  localparam int unsigned CODE_W = DATA_W + P + 1;
  localparam int unsigned POS_W  = $clog2(CODE_W);

  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic [P-1:0]      s1_syn;
  logic              s1_ovr;
  logic [P-1:0]      syn_c;
  logic              ovr_c;
  logic              s2_load;

  assign s2_load      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_load;

  // Syndrome and overall check on the incoming word
  always_comb begin
    syn_c = '0;
    for (int k = 0; k < P; k++) begin
      syn_c[k] = bus.in_parity_type;
      for (int i = 1; i < CODE_W; i++) begin
        if (((i >> k) & 1) == 1) syn_c[k] = syn_c[k] ^ bus.in_code[i];
      end
    end
    ovr_c = (^bus.in_code) ^ bus.in_parity_type;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_ovr   <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_code <= bus.in_code;
        s1_syn  <= syn_c;
        s1_ovr  <= ovr_c;
      end
    end
  end

  logic [CODE_W-1:0] fixed_c;
  logic [DATA_W-1:0] data_c;
  logic              single_c;
  logic              double_c;
  logic [POS_W-1:0]  pos_c;
  logic              syn_nz;
  logic              syn_in_range;

  assign syn_nz       = |s1_syn;
  assign syn_in_range = {1'b0, s1_syn} < (P+1)'(CODE_W);

  // Classify, correct and extract data (out-of-range syndrome with odd overall is uncorrectable)
  always_comb begin
    int unsigned j;
    j        = 0;
    single_c = 1'b0;
    double_c = 1'b0;
    pos_c    = '0;
    fixed_c  = s1_code;
    data_c   = '0;
    if (s1_ovr) begin
      if (!syn_nz) begin
        single_c = 1'b1;
      end else if (syn_in_range) begin
        single_c        = 1'b1;
        pos_c           = POS_W'(s1_syn);
        fixed_c[pos_c]  = ~s1_code[pos_c];
      end else begin
        double_c = 1'b1;
      end
    end else if (syn_nz) begin
      double_c = 1'b1;
    end
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        data_c[j] = fixed_c[i];
        j++;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid      <= 1'b0;
      bus.out_data       <= '0;
      bus.out_single_err <= 1'b0;
      bus.out_double_err <= 1'b0;
      bus.out_err_pos    <= '0;
    end else if (s2_load) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_data       <= data_c;
        bus.out_single_err <= single_c;
        bus.out_double_err <= double_c;
        bus.out_err_pos    <= pos_c;
      end
    end
  end

`ifdef HAMM_ERR_CNT_EN
  logic out_acc_c;
  assign out_acc_c = bus.out_valid && bus.out_ready;

  // Saturating counters; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_acc_c) begin
      if (bus.out_single_err && !(&corr_cnt))   corr_cnt   <= corr_cnt + CNT_W'(1);
      if (bus.out_double_err && !(&uncorr_cnt)) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif
endmodule
